sram_port_arbiter: RTL and testbench
====================================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter: WFIFO_DEPTH, 4, posted-write FIFO depth in entries (power of two, >=2).
REQ-002 SHALL have port: clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: cap_we_n  input  1  capture write strobe, active low, one word per low cycle.
REQ-005 SHALL have port: cap_addr  input  18  capture write address.
REQ-006 SHALL have port: cap_wd  input  32  capture write data.
REQ-007 SHALL have port: rd_req  input  1  reader request, level; held with rd_addr stable until rd_ack.
REQ-008 SHALL have port: rd_addr  input  18  reader address.
REQ-009 SHALL have port: rd_ack  output  1  one-cycle pulse: read issued to SRAM.
REQ-010 SHALL have port: rd_valid  output  1  one-cycle pulse: rd_data holds read result.
REQ-011 SHALL have port: rd_data  output  32  read data, held until next rd_valid.
REQ-012 SHALL have port: sram_we_n  output  1  SRAM write enable, active low.
REQ-013 SHALL have port: sram_oe_n  output  1  SRAM output enable, active low.
REQ-014 SHALL have port: sram_addr  output  18  SRAM address.
REQ-015 SHALL have port: sram_wd  output  32  SRAM write data.
REQ-016 SHALL have port: sram_rd  input  32  SRAM read data.
REQ-017 SHALL have port: drop_cnt  output  16  count of capture writes lost to FIFO full, saturating.
REQ-018 SHALL have port: wfifo_level  output  3  current FIFO occupancy, 0..WFIFO_DEPTH.

Function
REQ-019 Every cycle with cap_we_n=0 SHALL push {cap_addr,cap_wd} into the FIFO unless full after that cycle's pop.
REQ-020 Push into full FIFO with no same-cycle pop SHALL drop the word; drop_cnt increments by 1, holds at 16'hFFFF.
REQ-021 Push and pop in the same cycle SHALL both occur; level unchanged; no drop.
REQ-022 Arbiter SHALL be a 3-state machine with one state per cycle: IDLE, WRITE (pop and drive write), READ (issue read); all SRAM outputs registered.
REQ-023 Grant decision, each cycle: FIFO empty and rd_req=1 -> READ; FIFO nonempty and rd_req=0 -> WRITE; neither -> IDLE.
REQ-024 Both pending: level >= WFIFO_DEPTH-1 -> WRITE; else opposite of last non-IDLE grant (alternation); last grant after reset treated as READ.
REQ-025 READ SHALL not be granted while a previous read is in flight (rd_ack issued, rd_valid not yet asserted).
REQ-026 WRITE cycle: sram_we_n=0, sram_oe_n=1, sram_addr/sram_wd = FIFO head, one cycle.
REQ-027 READ cycle: sram_oe_n=0, sram_we_n=1, sram_addr=rd_addr, rd_ack=1 in the same cycle.
REQ-028 IDLE: sram_we_n=1, sram_oe_n=1; sram_addr and sram_wd hold last value.
REQ-029 rd_valid SHALL assert exactly 2 cycles after rd_ack; rd_data = sram_rd sampled at the edge ending the cycle after the READ cycle.
REQ-030 sram_we_n and sram_oe_n SHALL never both be 0.
REQ-031 FIFO order SHALL be strict: words written to SRAM in push order; pointers wrap modulo WFIFO_DEPTH.
REQ-032 rd_req dropped before rd_ack SHALL cancel the request without a read.

Reset
REQ-033 reset_n=0 SHALL immediately force: sram_we_n=1, sram_oe_n=1, sram_addr=0, sram_wd=0, rd_ack=0, rd_valid=0, rd_data=0, drop_cnt=0, wfifo_level=0, state IDLE.
REQ-034 Reset mid-operation SHALL discard FIFO contents and any in-flight read; no rd_valid follows.

Verification
REQ-035 Single write: cap_we_n low 1 cycle, addr 18'h00010, wd 32'hA5A5A5A5, no reads -> one WRITE cycle with those values, level returns to 0.
REQ-036 Single read: rd_req with rd_addr 18'h00020, sram_rd model returns 32'h12345678 -> rd_ack at issue, rd_valid 2 cycles later, rd_data=32'h12345678.
REQ-037 Contention: cap_we_n low every 4th cycle and rd_req continuous -> grants alternate, no drops, write order preserved, no cycle with both strobes low.
REQ-038 Overflow: WFIFO_DEPTH=4, cap_we_n low every cycle and rd_req continuous -> writes win at level>=3, drop_cnt increments only on pushes at full without pop.
REQ-039 Saturation: force 70000 drops -> drop_cnt stays 16'hFFFF.
REQ-040 Reset during in-flight read and level 2 -> all outputs at reset values, no rd_valid, level 0 after release.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - single-port SRAM arbiter between posted capture writes and a blocking reader
module sram_port_arbiter #(
    parameter int WFIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cap_we_n,
    input  logic [17:0] cap_addr,
    input  logic [31:0] cap_wd,
    input  logic        rd_req,
    input  logic [17:0] rd_addr,
    output logic        rd_ack,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic [17:0] sram_addr,
    output logic [31:0] sram_wd,
    input  logic [31:0] sram_rd,
    output logic [15:0] drop_cnt,
    output logic [2:0]  wfifo_level
);

    localparam int AW = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
    localparam int LW = $clog2(WFIFO_DEPTH + 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(WFIFO_DEPTH);
    localparam logic [LW-1:0] HIGH_LVL = LW'(WFIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [49:0]    r_mem [WFIFO_DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [LW-1:0]  r_level;
    logic [15:0]    r_drop;

    logic           r_last_rd;
    logic           r_rd_p1;
    logic           r_we_n;
    logic           r_oe_n;
    logic           r_ack;
    logic           r_valid;
    logic [17:0]    r_addr;
    logic [31:0]    r_wd;
    logic [31:0]    r_rdata;

    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_push_ok;
    logic           w_drop;
    logic           w_wr_pend;
    logic           w_rd_busy;
    logic           w_rd_pend;
    logic [49:0]    w_head;

    assign w_push    = ~cap_we_n;
    assign w_full    = (r_level == FULL_LVL);
    assign w_pop     = (w_state_nxt == S_WRITE);
    // A full FIFO still accepts a word when the same edge pops one.
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;
    assign w_head    = r_mem[r_rptr];

    assign w_wr_pend = (r_level != '0);
    assign w_rd_busy = (r_state == S_READ) | r_rd_p1;
    assign w_rd_pend = rd_req & ~w_rd_busy;

    always_comb begin
        w_state_nxt = S_IDLE;
        if (w_wr_pend && w_rd_pend) begin
            // Near-full forces a drain; otherwise take turns with the reader.
            if ((r_level >= HIGH_LVL) || r_last_rd) begin
                w_state_nxt = S_WRITE;
            end else begin
                w_state_nxt = S_READ;
            end
        end else if (w_wr_pend) begin
            w_state_nxt = S_WRITE;
        end else if (w_rd_pend) begin
            w_state_nxt = S_READ;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= {cap_addr, cap_wd};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_drop  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_level <= r_level + LW'(w_push_ok) - LW'(w_pop);
            if (w_drop && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_addr    <= '0;
            r_wd      <= '0;
            r_ack     <= 1'b0;
            r_rd_p1   <= 1'b0;
            r_valid   <= 1'b0;
            r_rdata   <= '0;
            r_last_rd <= 1'b1;
        end else begin
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_ack   <= 1'b0;
            r_rd_p1 <= r_ack;
            r_valid <= r_rd_p1;
            if (r_rd_p1) begin
                r_rdata <= sram_rd;
            end
            case (w_state_nxt)
                S_WRITE: begin
                    r_we_n    <= 1'b0;
                    r_addr    <= w_head[49:32];
                    r_wd      <= w_head[31:0];
                    r_last_rd <= 1'b0;
                end
                S_READ: begin
                    r_oe_n    <= 1'b0;
                    r_addr    <= rd_addr;
                    r_ack     <= 1'b1;
                    r_last_rd <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign sram_we_n   = r_we_n;
    assign sram_oe_n   = r_oe_n;
    assign sram_addr   = r_addr;
    assign sram_wd     = r_wd;
    assign rd_ack      = r_ack;
    assign rd_valid    = r_valid;
    assign rd_data     = r_rdata;
    assign drop_cnt    = r_drop;
    assign wfifo_level = 3'(r_level);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - randomized bench with a queue-based reference model of the arbiter
module tb_sram_port_arbiter;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cap_we_n;
    logic [17:0] cap_addr;
    logic [31:0] cap_wd;
    logic        rd_req;
    logic [17:0] rd_addr;
    logic        rd_ack;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic [17:0] sram_addr;
    logic [31:0] sram_wd;
    logic [31:0] sram_rd;
    logic [15:0] drop_cnt;
    logic [2:0]  wfifo_level;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] sram_mem [0:262143];
    logic [31:0] m_mem    [0:262143];

    logic [49:0] q[$];
    logic        m_last_rd;
    int          m_since;
    logic [31:0] m_pend;
    logic        e_we_n, e_oe_n, e_ack, e_valid;
    logic [17:0] e_addr;
    logic [31:0] e_wd, e_rdata;
    logic [15:0] e_drop;

    always #5 clk = ~clk;

    sram_port_arbiter #(.WFIFO_DEPTH(D)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cap_we_n    (cap_we_n),
        .cap_addr    (cap_addr),
        .cap_wd      (cap_wd),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n),
        .sram_addr   (sram_addr),
        .sram_wd     (sram_wd),
        .sram_rd     (sram_rd),
        .drop_cnt    (drop_cnt),
        .wfifo_level (wfifo_level)
    );

    function automatic logic [31:0] mem_init(input int i);
        return 32'h12345678 + 32'(i - 32) * 32'h00010003;
    endfunction

    // Synchronous SRAM: read data appears the cycle after the output-enable cycle.
    initial begin
        for (int i = 0; i < 262144; i++) sram_mem[i] = mem_init(i);
        sram_rd <= '0;
        forever begin
            @(posedge clk);
            if (!sram_we_n) sram_mem[sram_addr] = sram_wd;
            if (!sram_oe_n) sram_rd <= sram_mem[sram_addr];
        end
    end

    function automatic logic [104:0] act_v();
        return {sram_we_n, sram_oe_n, rd_ack, rd_valid, sram_addr, sram_wd, rd_data, drop_cnt, wfifo_level};
    endfunction

    function automatic logic [104:0] exp_v();
        return {e_we_n, e_oe_n, e_ack, e_valid, e_addr, e_wd, e_rdata, e_drop, 3'(q.size())};
    endfunction

    task automatic reset_model();
        q.delete();
        m_last_rd = 1'b1;
        m_since   = 1000;
        m_pend    = '0;
        e_we_n = 1'b1; e_oe_n = 1'b1; e_ack = 1'b0; e_valid = 1'b0;
        e_addr = '0; e_wd = '0; e_rdata = '0; e_drop = '0;
    endtask

    task automatic model_edge();
        bit          wr_p, rd_p;
        int          g;
        logic [49:0] h;
        wr_p = (q.size() != 0);
        rd_p = rd_req && (m_since >= 2);
        if (wr_p && rd_p) g = (q.size() >= D - 1 || m_last_rd) ? 1 : 2;
        else if (wr_p)    g = 1;
        else if (rd_p)    g = 2;
        else              g = 0;
        e_valid = (m_since == 1);
        if (e_valid) e_rdata = m_pend;
        if (m_since < 1000) m_since++;
        e_we_n = 1'b1; e_oe_n = 1'b1; e_ack = 1'b0;
        if (g == 1) begin
            h = q.pop_front();
            e_we_n = 1'b0; e_addr = h[49:32]; e_wd = h[31:0];
            m_mem[h[49:32]] = h[31:0];
            m_last_rd = 1'b0;
        end else if (g == 2) begin
            e_oe_n = 1'b0; e_addr = rd_addr; e_ack = 1'b1;
            m_pend = m_mem[rd_addr];
            m_since = 0;
            m_last_rd = 1'b1;
        end
        if (!cap_we_n) begin
            if (q.size() < D) q.push_back({cap_addr, cap_wd});
            else if (e_drop != 16'hFFFF) e_drop++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic next_reader(input int p_req, input int p_cancel);
        if (rd_req && e_ack) begin
            rd_req  = (int'($urandom_range(0, 99)) < p_req);
            rd_addr = 18'($urandom_range(0, 63));
        end else if (rd_req) begin
            if (int'($urandom_range(0, 99)) < p_cancel) rd_req = 1'b0;
        end else if (int'($urandom_range(0, 99)) < p_req) begin
            rd_req  = 1'b1;
            rd_addr = 18'($urandom_range(0, 63));
        end
    endtask

    task automatic drain();
        cap_we_n = 1'b1;
        rd_req   = 1'b0;
        repeat (8) step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cap_we_n = 1'b1; rd_req = 1'b0;
        cap_addr = '0; cap_wd = '0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (act_v() !== {2'b11, 103'd0}) begin
            n_err++; $display("FAIL reset_state got %h exp %h", act_v(), {2'b11, 103'd0});
        end
        @(negedge clk);
        reset_n = 1'b1;
        reset_model();
        step();
        n_vec++;
        if (act_v() !== exp_v()) begin
            n_err++; $display("FAIL reset_release got %h exp %h", act_v(), exp_v());
        end
    endtask

    task automatic test_single_write();
        int saw = 0;
        cap_we_n = 1'b0; cap_addr = 18'h00010; cap_wd = 32'hA5A5A5A5;
        step();
        n_vec++;
        if (act_v() !== exp_v()) begin
            n_err++; $display("FAIL single_write_push got %h exp %h", act_v(), exp_v());
        end
        cap_we_n = 1'b1;
        repeat (4) begin
            step();
            n_vec++;
            if (act_v() !== exp_v()) begin
                n_err++; $display("FAIL single_write got %h exp %h", act_v(), exp_v());
            end
            if (!sram_we_n && sram_addr == 18'h00010 && sram_wd == 32'hA5A5A5A5) saw++;
        end
        n_vec++;
        if (saw !== 1 || wfifo_level !== 3'd0) begin
            n_err++; $display("FAIL single_write_cycles got %0d/%0d exp 1/0", saw, wfifo_level);
        end
    endtask

    task automatic test_single_read();
        int ack_c = -1;
        int val_c = -1;
        rd_addr = 18'h00020; rd_req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            n_vec++;
            if (act_v() !== exp_v()) begin
                n_err++; $display("FAIL single_read cyc %0d got %h exp %h", c, act_v(), exp_v());
            end
            if (rd_ack && ack_c < 0) ack_c = c;
            if (rd_valid && val_c < 0) val_c = c;
            if (e_ack) rd_req = 1'b0;
        end
        n_vec++;
        if (ack_c < 0 || val_c - ack_c !== 2) begin
            n_err++; $display("FAIL read_latency got ack %0d valid %0d exp distance 2", ack_c, val_c);
        end
        n_vec++;
        if (rd_data !== 32'h12345678) begin
            n_err++; $display("FAIL read_data got %h exp 12345678", rd_data);
        end
    endtask

    task automatic test_contention(input int period, input int cycles, input string tag);
        rd_req = 1'b1; rd_addr = 18'($urandom_range(0, 63));
        for (int c = 0; c < cycles; c++) begin
            cap_we_n = (c % period != 0);
            cap_addr = 18'($urandom_range(0, 63));
            cap_wd   = $urandom;
            step();
            n_vec++;
            if (act_v() !== exp_v()) begin
                n_err++; $display("FAIL %s cyc %0d got %h exp %h", tag, c, act_v(), exp_v());
            end
            n_vec++;
            if (!sram_we_n && !sram_oe_n) begin
                n_err++; $display("FAIL %s_strobes cyc %0d got we_n=0 oe_n=0 exp not both 0", tag, c);
            end
            next_reader(100, 0);
        end
        n_vec++;
        if (drop_cnt !== 16'd0) begin
            n_err++; $display("FAIL %s_drops got %0d exp 0", tag, drop_cnt);
        end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            cap_we_n = (int'($urandom_range(0, 99)) >= 40);
            cap_addr = 18'($urandom_range(0, 63));
            cap_wd   = $urandom;
            step();
            n_vec++;
            if (act_v() !== exp_v()) begin
                n_err++; $display("FAIL random cyc %0d got %h exp %h", c, act_v(), exp_v());
            end
            next_reader(50, 10);
        end
        drain();
    endtask

    task automatic test_reset_midop();
        int c = 0;
        cap_we_n = 1'b0; cap_addr = 18'h3; cap_wd = $urandom; rd_req = 1'b0;
        step();
        rd_req = 1'b1; rd_addr = 18'h5;
        while (!(e_ack && q.size() == 2) && c < 20) begin
            cap_addr = 18'($urandom_range(0, 63)); cap_wd = $urandom;
            step();
            n_vec++;
            if (act_v() !== exp_v()) begin
                n_err++; $display("FAIL midop_setup cyc %0d got %h exp %h", c, act_v(), exp_v());
            end
            c++;
        end
        n_vec++;
        if (rd_ack !== 1'b1 || wfifo_level !== 3'd2) begin
            n_err++; $display("FAIL midop_precondition got ack %b level %0d exp 1/2", rd_ack, wfifo_level);
        end
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if (act_v() !== {2'b11, 103'd0}) begin
            n_err++; $display("FAIL midop_async_reset got %h exp %h", act_v(), {2'b11, 103'd0});
        end
        cap_we_n = 1'b1; rd_req = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (act_v() !== {2'b11, 103'd0}) begin
            n_err++; $display("FAIL midop_held_reset got %h exp %h", act_v(), {2'b11, 103'd0});
        end
        @(negedge clk);
        reset_n = 1'b1;
        reset_model();
        repeat (5) begin
            step();
            n_vec++;
            if (act_v() !== exp_v() || rd_valid !== 1'b0) begin
                n_err++; $display("FAIL midop_after got %h exp %h", act_v(), exp_v());
            end
        end
        n_vec++;
        if (wfifo_level !== 3'd0) begin
            n_err++; $display("FAIL midop_level got %0d exp 0", wfifo_level);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] exp16;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rd_req = 1'b0; cap_we_n = 1'b0;
        // The arbiter always drains before the FIFO can fill, so pin it full and stall pops.
        force dut.r_level = 3'd4;
        force dut.w_pop   = 1'b0;
        for (int n = 1; n <= 70000; n++) begin
            @(posedge clk);
            if (n == 100 || n == 65534 || n == 70000) begin
                #1;
                exp16 = (n == 100) ? 16'd100 : ((n == 65534) ? 16'hFFFE : 16'hFFFF);
                n_vec++;
                if (drop_cnt !== exp16) begin
                    n_err++; $display("FAIL saturation at %0d drops got %h exp %h", n, drop_cnt, exp16);
                end
            end
        end
        release dut.w_pop;
        release dut.r_level;
        cap_we_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (act_v() !== {2'b11, 103'd0}) begin
            n_err++; $display("FAIL saturation_reset got %h exp %h", act_v(), {2'b11, 103'd0});
        end
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) m_mem[i] = mem_init(i);
        test_reset();
        test_single_write();
        test_single_read();
        drain();
        test_contention(4, 240, "contention");
        test_contention(1, 240, "overflow");
        test_random();
        test_reset_midop();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
